// File: rtl/wb_pkg.sv
// Shared encodings for the writeback/load stage: result-source selects,
// RISC-V load funct3 values and the stage FSM states.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_PCP4 = 2'd1;
  localparam logic [1:0] WB_SEL_LOAD = 2'd2;
  localparam logic [1:0] WB_SEL_CSR  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_RAW = 3'b111;

  typedef enum logic {
    WB_IDLE,
    WB_WAIT_MEM
  } wb_state_e;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load alignment and sign/zero extension of a naturally
// aligned memory word; shared with any future forwarding path.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ALO_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [2:0]       funct3,
  input  logic [ALO_W-1:0] alo,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {alo, 3'b000};
    data    = rdata;
    // Size casts of $signed operands sign-extend; unsigned ones zero-extend.
    case (funct3)
      F3_LB:   data = XLEN'($signed(shifted[7:0]));
      F3_LBU:  data = XLEN'(shifted[7:0]);
      F3_LH:   data = XLEN'($signed(shifted[15:0]));
      F3_LHU:  data = XLEN'(shifted[15:0]);
      F3_LW:   data = XLEN'($signed(shifted[31:0]));
      F3_LWU:  data = (XLEN == 64) ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      F3_LD:   data = (XLEN == 64) ? shifted : XLEN'($signed(shifted[31:0]));
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage_lsu.sv
// Writeback stage: selects the result source, waits for late load data and
// emits a one-cycle register-file write. Optional WB_MISALIGN_TRAP_EN adds a misalign pulse.
module wb_stage_lsu
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ALO_W = $clog2(XLEN / 8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_sel,
  input  logic [XLEN-1:0]  in_res,
  input  logic [XLEN-1:0]  in_pcp4,
  input  logic [XLEN-1:0]  in_csr,
  input  logic [2:0]       in_funct3,
  input  logic [ALO_W-1:0] in_alo,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             busy
`ifdef WB_MISALIGN_TRAP_EN
  ,
  output logic             misalign
`endif
);

  wb_state_e        state, state_next;
  logic [4:0]       lat_rd;
  logic [2:0]       lat_f3;
  logic [ALO_W-1:0] lat_alo;

  logic             accept;
  logic             is_load;
  logic             commit_load;
  logic             commit;
  logic             commit_mis;
  logic             enter_wait;
  logic [4:0]       commit_rd;
  logic [2:0]       ext_f3;
  logic [ALO_W-1:0] ext_alo;
  logic [XLEN-1:0]  ext_data;
  logic [XLEN-1:0]  commit_data;

`ifdef WB_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [ALO_W-1:0] alo);
    case (f3)
      F3_LH, F3_LHU:  return alo[0];
      F3_LW, F3_LWU:  return |alo[1:0];
      F3_LD:          return (XLEN == 64) ? |alo : |alo[1:0];
      default:        return 1'b0;
    endcase
  endfunction
`endif

  wb_load_ext #(
    .XLEN  (XLEN),
    .ALO_W (ALO_W)
  ) u_load_ext (
    .rdata  (mem_rdata),
    .funct3 (ext_f3),
    .alo    (ext_alo),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WB_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WB_IDLE:     if (enter_wait) state_next = WB_WAIT_MEM;
      WB_WAIT_MEM: if (flush || mem_rvalid) state_next = WB_IDLE;
      default:     state_next = WB_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == WB_IDLE);
    busy     = (state == WB_WAIT_MEM);
  end

  always_comb begin
    accept      = in_valid && (state == WB_IDLE);
    is_load     = (in_sel == WB_SEL_LOAD);
    enter_wait  = accept && is_load && !mem_rvalid && !flush;
    // In WAIT_MEM the latched fields drive the extractor, otherwise the live inputs.
    ext_f3      = (state == WB_WAIT_MEM) ? lat_f3  : in_funct3;
    ext_alo     = (state == WB_WAIT_MEM) ? lat_alo : in_alo;
    commit_rd   = (state == WB_WAIT_MEM) ? lat_rd  : in_rd;
    commit_load = mem_rvalid && ((state == WB_WAIT_MEM) || (accept && is_load));
    commit      = !flush && (commit_load || (accept && !is_load));
`ifdef WB_MISALIGN_TRAP_EN
    commit_mis  = commit && commit_load && is_misaligned(ext_f3, ext_alo);
`else
    commit_mis  = 1'b0;
`endif
    case (in_sel)
      WB_SEL_ALU:  commit_data = in_res;
      WB_SEL_PCP4: commit_data = in_pcp4;
      WB_SEL_CSR:  commit_data = in_csr;
      default:     commit_data = ext_data;
    endcase
    if (state == WB_WAIT_MEM) commit_data = ext_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rd   <= '0;
      lat_f3   <= '0;
      lat_alo  <= '0;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      if (enter_wait) begin
        lat_rd  <= in_rd;
        lat_f3  <= in_funct3;
        lat_alo <= in_alo;
      end
      rf_we <= commit && !commit_mis && (commit_rd != 5'd0);
      if (commit && !commit_mis) begin
        rf_rd    <= commit_rd;
        rf_wdata <= commit_data;
      end
    end
  end

`ifdef WB_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= commit_mis;
  end
`endif

endmodule

// File: tb/tb_wb_stage_lsu.sv
// Scoreboard bench for wb_stage_lsu: a driver pushes expected writes computed
// from a behavioural load model; a monitor pops them when the DUT writes.
module tb_wb_stage_lsu;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ALO_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush, in_valid, in_ready;
  logic [4:0]       in_rd;
  logic [1:0]       in_sel;
  logic [XLEN-1:0]  in_res, in_pcp4, in_csr;
  logic [2:0]       in_funct3;
  logic [ALO_W-1:0] in_alo;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;
  logic             rf_we;
  logic [4:0]       rf_rd;
  logic [XLEN-1:0]  rf_wdata;
  logic             busy;
  logic             mis_s;

  wb_stage_lsu #(.XLEN(XLEN), .ALO_W(ALO_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_sel(in_sel), .in_res(in_res), .in_pcp4(in_pcp4), .in_csr(in_csr),
    .in_funct3(in_funct3), .in_alo(in_alo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy)
`ifdef WB_MISALIGN_TRAP_EN
    , .misalign(mis_s)
`endif
  );
`ifndef WB_MISALIGN_TRAP_EN
  assign mis_s = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    bit              mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  bit              pending = 0;
  logic [4:0]      p_rd;
  logic [2:0]      p_f3;
  logic [ALO_W-1:0] p_alo;

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference load semantics from the ISA rules, using plain integer arithmetic.
  function automatic logic [XLEN-1:0] ref_load(input logic [XLEN-1:0] rdata, input logic [2:0] f3,
                                               input logic [ALO_W-1:0] alo);
    longint s;
    longint v;
    int     size;
    bit     sgn;
    s = longint'(64'(rdata) >> (int'(alo) * 8));
    size = 4; sgn = 1;
    case (f3)
      3'b000: begin size = 1; sgn = 1; end
      3'b100: begin size = 1; sgn = 0; end
      3'b001: begin size = 2; sgn = 1; end
      3'b101: begin size = 2; sgn = 0; end
      3'b110: begin size = 4; sgn = (XLEN != 64); end
      3'b011: begin size = (XLEN == 64) ? 8 : 4; sgn = 1; end
      3'b111: return rdata;
      default: begin size = 4; sgn = 1; end
    endcase
    if (size == 8) return XLEN'(s);
    v = s % (64'sd1 << (size * 8));
    if (v < 0) v += (64'sd1 << (size * 8));
    if (sgn && v >= (64'sd1 << (size * 8 - 1))) v -= (64'sd1 << (size * 8));
    return XLEN'(v);
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [ALO_W-1:0] alo);
    int a;
    int sz;
    a = int'(alo);
    case (f3)
      3'b001, 3'b101: sz = 2;
      3'b010, 3'b110: sz = 4;
      3'b011:         sz = (XLEN == 64) ? 8 : 4;
      default:        sz = 1;
    endcase
    return (a % sz) != 0;
  endfunction

  task automatic push_exp(input logic [4:0] rd, input logic [XLEN-1:0] data, input bit mis);
    exp_t e;
    e.rd = rd; e.data = data; e.mis = mis;
    if (mis || rd != 5'd0) exp_q.push_back(e);
  endtask

  task automatic expect_load(input logic [4:0] rd, input logic [2:0] f3, input logic [ALO_W-1:0] alo,
                             input logic [XLEN-1:0] rdata);
    bit mis;
`ifdef WB_MISALIGN_TRAP_EN
    mis = ref_mis(f3, alo);
`else
    mis = 0;
`endif
    push_exp(rd, ref_load(rdata, f3, alo), mis);
  endtask

  task automatic drive(input bit v, input logic [1:0] sel, input logic [4:0] rd,
                       input logic [XLEN-1:0] res, input logic [XLEN-1:0] pcp4, input logic [XLEN-1:0] csr,
                       input logic [2:0] f3, input logic [ALO_W-1:0] alo,
                       input bit rv, input logic [XLEN-1:0] rdata, input bit fl);
    @(posedge clk); #1;
    check1("in_ready", 64'(in_ready), 64'(!pending));
    check1("busy", 64'(busy), 64'(pending));
    in_valid = v; in_sel = sel; in_rd = rd; in_res = res; in_pcp4 = pcp4; in_csr = csr;
    in_funct3 = f3; in_alo = alo; mem_rvalid = rv; mem_rdata = rdata; flush = fl;
    if (!pending) begin
      if (v && !fl) begin
        if (sel == 2'd0)      push_exp(rd, res, 0);
        else if (sel == 2'd1) push_exp(rd, pcp4, 0);
        else if (sel == 2'd3) push_exp(rd, csr, 0);
        else if (rv)          expect_load(rd, f3, alo, rdata);
        else begin
          pending = 1; p_rd = rd; p_f3 = f3; p_alo = alo;
        end
      end
    end else begin
      if (fl) pending = 0;
      else if (rv) begin
        expect_load(p_rd, p_f3, p_alo, rdata);
        pending = 0;
      end
    end
  endtask

  task automatic idle(input bit rv);
    drive(0, 2'd0, 5'd0, '0, '0, '0, 3'd0, '0, rv, $urandom, 0);
  endtask

  // Monitor: every write or misalign pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rf_we || mis_s)) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_write: got we=%0d mis=%0d rd=%0d data=%h, want no write",
                   rf_we, mis_s, rf_rd, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          check1("misalign", 64'(mis_s), 64'(e.mis));
          if (e.mis) check1("we_on_mis", 64'(rf_we), 64'd0);
          else begin
            check1("rf_rd", 64'(rf_rd), 64'(e.rd));
            check1("rf_wdata", 64'(rf_wdata), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_rd = '0; in_sel = '0; in_res = '0; in_pcp4 = '0;
    in_csr = '0; in_funct3 = '0; in_alo = '0; mem_rvalid = 0; mem_rdata = '0;
    #1;
    check1("rst_we", 64'(rf_we), 64'd0);
    check1("rst_rd", 64'(rf_rd), 64'd0);
    check1("rst_wdata", 64'(rf_wdata), 64'd0);
    check1("rst_busy", 64'(busy), 64'd0);
    check1("rst_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Directed cases
    drive(1, 2'd0, 5'd5, 32'h1234_5678, '0, '0, 3'd0, '0, 0, '0, 0);
    idle(0);
    drive(1, 2'd2, 5'd7, '0, '0, '0, 3'b000, 2'd3, 1, 32'h80FF_0000, 0);
    drive(1, 2'd2, 5'd8, '0, '0, '0, 3'b100, 2'd3, 1, 32'h80FF_0000, 0);
    drive(1, 2'd2, 5'd9, '0, '0, '0, 3'b001, 2'd2, 0, '0, 0);
    repeat (3) idle(0);
    idle(0);
    drive(0, 2'd0, 5'd0, '0, '0, '0, 3'd0, '0, 1, 32'h8001_0000, 0);
    drive(1, 2'd2, 5'd10, '0, '0, '0, 3'b010, 2'd0, 0, '0, 0);
    drive(0, 2'd0, 5'd0, '0, '0, '0, 3'd0, '0, 1, 32'hDEAD_BEEF, 1);
    idle(1);
    drive(1, 2'd1, 5'd0, '0, 32'h0000_1004, '0, 3'd0, '0, 0, '0, 0);
    drive(1, 2'd3, 5'd31, '0, '0, 32'hCAFE_0001, 3'd0, '0, 0, '0, 0);
    drive(1, 2'd0, 5'd4, 32'h5555_AAAA, '0, '0, 3'd0, '0, 0, '0, 1);
    drive(1, 2'd2, 5'd12, '0, '0, '0, 3'b010, 2'd1, 1, 32'h1122_3344, 0);
    drive(1, 2'd2, 5'd13, '0, '0, '0, 3'b111, 2'd2, 1, 32'h99AA_BBCC, 0);
    idle(0);

    // Reset while waiting for load data
    drive(1, 2'd2, 5'd14, '0, '0, '0, 3'b010, 2'd0, 0, '0, 0);
    idle(0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check1("midrst_we", 64'(rf_we), 64'd0);
    check1("midrst_busy", 64'(busy), 64'd0);
    check1("midrst_ready", 64'(in_ready), 64'd1);
    pending = 0; in_valid = 0; mem_rvalid = 0; flush = 0;
    @(negedge clk);
    rst_n = 1;
    idle(1);
    idle(0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (pending)
        drive($urandom_range(0, 1), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
              3'($urandom), ALO_W'($urandom), $urandom_range(0, 2) == 0, $urandom,
              $urandom_range(0, 9) == 0);
      else
        drive($urandom_range(0, 3) != 0, 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
              3'($urandom), ALO_W'($urandom), $urandom_range(0, 1) == 1, $urandom,
              $urandom_range(0, 9) == 0);
    end
    repeat (2) begin
      if (pending) drive(0, 2'd0, 5'd0, '0, '0, '0, 3'd0, '0, 0, '0, 1);
      else idle(0);
    end
    repeat (2) idle(0);
    check1("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
